wb_timer: RTL

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer_pkg.sv | 57 +++++
 rtl/wb_timer_prescaler.sv | 28 ++
 rtl/wb_timer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
// Shared constants, register-map offsets and register-file types for the machine timer.
package wb_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SEL_W      = DATA_W / 8;
    localparam int unsigned MTIME_W    = 64;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned OFS_W      = 8;

    // Byte offsets of the mapped registers inside the decoded window
    localparam logic [OFS_W-1:0] MTIME_LO_OFS    = 8'h00;
    localparam logic [OFS_W-1:0] MTIME_HI_OFS    = 8'h04;
    localparam logic [OFS_W-1:0] MTIMECMP_LO_OFS = 8'h08;
    localparam logic [OFS_W-1:0] MTIMECMP_HI_OFS = 8'h0C;
    localparam logic [OFS_W-1:0] PRESCALE_OFS    = 8'h10;

    // Compare value parked at the maximum so no interrupt fires out of reset
    localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_PRESCALE,
        REG_NONE
    } reg_sel_e;

    typedef struct packed {
        logic [MTIME_W-1:0]    mtime;
        logic [MTIME_W-1:0]    mtimecmp;
        logic [PRESCALE_W-1:0] prescale;
    } timer_regs_t;

    localparam timer_regs_t TIMER_REGS_RST = '{
        mtime:    '0,
        mtimecmp: MTIMECMP_RST,
        prescale: '0
    };

    // Replace only the byte lanes flagged in sel; other lanes keep old_val
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [SEL_W-1:0]  sel
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int unsigned i = 0; i < SEL_W; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Free-running divider: counts 0..prescale and ticks on the terminal count.
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;

    // Terminal count reached; >= keeps the divider safe if count ever exceeds the limit
    assign tick = (count >= prescale);

    // Counter wraps on tick and restarts from zero whenever the divisor is rewritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/wb_timer.sv
// RISC-V style machine timer (mtime/mtimecmp) behind a pipelined Wishbone slave.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int unsigned size = 'h1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_adr,
    input  logic [DATA_W-1:0] wb_dat_m,
    output logic [DATA_W-1:0] wb_dat_s,
    input  logic [SEL_W-1:0]  wb_sel,
    input  logic              wb_we,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    output logic              wb_ack,
    output logic              wb_stall,
    output logic              wb_err,
    output logic              irq_timer
);

    localparam int unsigned AW = $clog2(size);
    localparam int unsigned WW = AW - 2;

    localparam logic [WW-1:0] W_MTIME_LO    = WW'(MTIME_LO_OFS[OFS_W-1:2]);
    localparam logic [WW-1:0] W_MTIME_HI    = WW'(MTIME_HI_OFS[OFS_W-1:2]);
    localparam logic [WW-1:0] W_MTIMECMP_LO = WW'(MTIMECMP_LO_OFS[OFS_W-1:2]);
    localparam logic [WW-1:0] W_MTIMECMP_HI = WW'(MTIMECMP_HI_OFS[OFS_W-1:2]);
    localparam logic [WW-1:0] W_PRESCALE    = WW'(PRESCALE_OFS[OFS_W-1:2]);

    timer_regs_t       regs;
    timer_regs_t       regs_next;
    reg_sel_e          reg_sel;
    logic [WW-1:0]     word_ofs;
    logic [DATA_W-1:0] rdata;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              wr_mtime_lo;
    logic              wr_mtime_hi;
    logic              wr_cmp_lo;
    logic              wr_cmp_hi;
    logic              wr_prescale;
    logic              tick;
    logic              unused_adr_bits;

    // Window base and sub-word byte address are resolved outside this block
    assign unused_adr_bits = ^{wb_adr[31:AW], wb_adr[1:0]};
    assign word_ofs        = wb_adr[AW-1:2];

    // Single-cycle slave: never stalls and never errors
    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;

    assign accept = wb_cyc & wb_stb;
    assign wr_en  = accept & wb_we;
    assign rd_en  = accept & ~wb_we;

    // Word-offset decode; anything outside the five registers maps to REG_NONE
    always_comb begin
        reg_sel = REG_NONE;
        if (word_ofs == W_MTIME_LO) begin
            reg_sel = REG_MTIME_LO;
        end else if (word_ofs == W_MTIME_HI) begin
            reg_sel = REG_MTIME_HI;
        end else if (word_ofs == W_MTIMECMP_LO) begin
            reg_sel = REG_MTIMECMP_LO;
        end else if (word_ofs == W_MTIMECMP_HI) begin
            reg_sel = REG_MTIMECMP_HI;
        end else if (word_ofs == W_PRESCALE) begin
            reg_sel = REG_PRESCALE;
        end
    end

    assign wr_mtime_lo = wr_en && (reg_sel == REG_MTIME_LO);
    assign wr_mtime_hi = wr_en && (reg_sel == REG_MTIME_HI);
    assign wr_cmp_lo   = wr_en && (reg_sel == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && (reg_sel == REG_MTIMECMP_HI);
    assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);

    wb_timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .prescale (regs.prescale),
        .clear    (wr_prescale),
        .tick     (tick)
    );

    // Read mux from current register state; unmapped words read zero
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_MTIME_LO:    rdata = regs.mtime[31:0];
            REG_MTIME_HI:    rdata = regs.mtime[63:32];
            REG_MTIMECMP_LO: rdata = regs.mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata = regs.mtimecmp[63:32];
            REG_PRESCALE:    rdata = DATA_W'(regs.prescale);
            default:         rdata = '0;
        endcase
    end

    // Register-file next state: a bus write to either mtime half pre-empts that cycle's increment
    always_comb begin
        regs_next = regs;
        if (wr_mtime_lo) begin
            regs_next.mtime[31:0] = merge_bytes(regs.mtime[31:0], wb_dat_m, wb_sel);
        end else if (wr_mtime_hi) begin
            regs_next.mtime[63:32] = merge_bytes(regs.mtime[63:32], wb_dat_m, wb_sel);
        end else if (tick) begin
            regs_next.mtime = regs.mtime + MTIME_W'(1);
        end
        if (wr_cmp_lo) begin
            regs_next.mtimecmp[31:0] = merge_bytes(regs.mtimecmp[31:0], wb_dat_m, wb_sel);
        end
        if (wr_cmp_hi) begin
            regs_next.mtimecmp[63:32] = merge_bytes(regs.mtimecmp[63:32], wb_dat_m, wb_sel);
        end
        if (wr_prescale) begin
            regs_next.prescale = PRESCALE_W'(merge_bytes(DATA_W'(regs.prescale), wb_dat_m, wb_sel));
        end
    end

    // Register file state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= TIMER_REGS_RST;
        end else begin
            regs <= regs_next;
        end
    end

    // Bus response: ack one cycle after accept, read data captured at the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_dat_s <= '0;
        end else begin
            wb_ack   <= accept;
            wb_dat_s <= rd_en ? rdata : '0;
        end
    end

    // Level interrupt from the registered compare; follows mtime/mtimecmp with one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_timer <= 1'b0;
        end else begin
            irq_timer <= (regs.mtime >= regs.mtimecmp);
        end
    end

endmodule
